// File: rtl/boc_sig_pkg.sv
// rtl/boc_sig_pkg.sv - shared constants for the B1 BOC(1,1) signal generator
// Purpose: amplitude, carrier cos/sin table, Gold-code LFSR seed and feedback
//          masks, NH secondary code.
// Ports:   none (package).
package boc_sig_pkg;

   localparam logic signed [15:0] AMP = 16'sd8192;

   // Eight carrier phases, 45 degrees apart, scaled by AMP.
   localparam logic signed [15:0] COS_TAB [8] = '{
      16'sd8192, 16'sd5793, 16'sd0, -16'sd5793,
      -16'sd8192, -16'sd5793, 16'sd0, 16'sd5793
   };
   localparam logic signed [15:0] SIN_TAB [8] = '{
      16'sd0, 16'sd5793, 16'sd8192, 16'sd5793,
      16'sd0, -16'sd5793, -16'sd8192, -16'sd5793
   };

   // Bit i holds LFSR stage i+1.
   localparam logic [10:0] LFSR_INIT = 11'b01010101010;
   // G1 = 1+x+x^7+x^8+x^9+x^10+x^11 -> stages 1,7,8,9,10,11
   localparam logic [10:0] G1_MASK = 11'b111_1100_0001;
   // G2 = 1+x+x^2+x^3+x^4+x^5+x^8+x^9+x^11 -> stages 1,2,3,4,5,8,9,11
   localparam logic [10:0] G2_MASK = 11'b101_1001_1111;

   // NH secondary code, MSB first.
   localparam int          NH_LEN  = 20;
   localparam logic [19:0] NH_CODE = 20'b00000100110101001110;

endpackage

// File: rtl/boc_sig_gen_if.sv
// rtl/boc_sig_gen_if.sv - nav handshake and sample stream bundle
// Purpose: groups the nav-bit valid/ready input and the complex sample output.
// Ports:   master = generator side (takes nav bits, drives samples),
//          slave  = consumer/feeder side.
interface boc_sig_gen_if;
   logic        rx_nav_bit;
   logic        rx_nav_vld;
   logic        tx_nav_rdy;
   logic [15:0] tx_sig_real;
   logic [15:0] tx_sig_imag;
   logic        tx_sig_vld;
   logic        tx_prn_sop;

   modport master (
      input  rx_nav_bit, rx_nav_vld,
      output tx_nav_rdy, tx_sig_real, tx_sig_imag, tx_sig_vld, tx_prn_sop
   );
   modport slave (
      output rx_nav_bit, rx_nav_vld,
      input  tx_nav_rdy, tx_sig_real, tx_sig_imag, tx_sig_vld, tx_prn_sop
   );
endinterface

// File: rtl/b1_prn_lfsr.sv
// rtl/b1_prn_lfsr.sv - B1 Gold-code G1/G2 LFSR pair
// Purpose: two 11-bit LFSRs with selectable G2 phase taps.
// Ports:   clk, rst (sync, active-high); adv shifts both registers one chip;
//          reload returns both to the seed (wins over adv); chip is the
//          current code chip, combinational from the register state.
module b1_prn_lfsr
   import boc_sig_pkg::*;
#(
   parameter int TAP_A = 1,
   parameter int TAP_B = 3
)(
   input  logic clk,
   input  logic rst,
   input  logic adv,
   input  logic reload,
   output logic chip
);

   logic [10:0] g1;
   logic [10:0] g2;

   assign chip = g1[10] ^ g2[TAP_A-1] ^ g2[TAP_B-1];

   always_ff @(posedge clk) begin
      if (rst || reload) begin
         g1 <= LFSR_INIT;
         g2 <= LFSR_INIT;
      end else if (adv) begin
         g1 <= {g1[9:0], ^(g1 & G1_MASK)};
         g2 <= {g2[9:0], ^(g2 & G2_MASK)};
      end
   end

endmodule

// File: rtl/boc_sig_gen.sv
// rtl/boc_sig_gen.sv - B1 BOC(1,1) baseband sample generator
// Purpose: carrier NCO, code NCO with BOC subcarrier, Gold-code PRN and
//          nav-bit modulation into registered complex 16-bit samples.
//          Define BOC_SIG_GEN_NH_EN to add the 20-bit NH secondary code.
// Ports:   rx_clk, rx_rst (sync, active-high); rx_en advances/freezes;
//          rx_car_fcw / rx_prn_fcw are the NCO words; sig (master) carries
//          the nav handshake and the sample stream; tx_nav_unf is the sticky
//          nav underflow flag.
module boc_sig_gen
   import boc_sig_pkg::*;
#(
   parameter int PRN_G2_TAP_A       = 1,
   parameter int PRN_G2_TAP_B       = 3,
   parameter int PRN_LEN            = 2046,
   parameter int SUBC_HALF_PER_CHIP = 2,
   parameter int CODES_PER_BIT      = 20
)(
   input  logic          rx_clk,
   input  logic          rx_rst,
   input  logic          rx_en,
   input  logic [31:0]   rx_car_fcw,
   input  logic [31:0]   rx_prn_fcw,
   output logic          tx_nav_unf,
   boc_sig_gen_if.master sig
);

   localparam int HC_W   = (SUBC_HALF_PER_CHIP > 1) ? $clog2(SUBC_HALF_PER_CHIP) : 1;
   localparam int CHIP_W = (PRN_LEN > 1) ? $clog2(PRN_LEN) : 1;
   localparam int CP_W   = (CODES_PER_BIT > 1) ? $clog2(CODES_PER_BIT) : 1;
   localparam logic [HC_W-1:0]   HC_LAST   = HC_W'(SUBC_HALF_PER_CHIP - 1);
   localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(PRN_LEN - 1);
   localparam logic [CP_W-1:0]   CP_LAST   = CP_W'(CODES_PER_BIT - 1);

   logic [31:0]        code_acc;
   logic [31:0]        car_acc;
   logic               subc;
   logic [HC_W-1:0]    hc_cnt;
   logic [CHIP_W-1:0]  chip_cnt;
   logic [CP_W-1:0]    cp_cnt;
   logic               nav_cur;
   logic               nav_buf;
   logic               sop_pend;   // next emitted sample opens a code period

   logic [32:0]        code_sum;
   logic               tick;
   logic               chip_adv;
   logic               chip_wrap;
   logic               cp_wrap;
   logic               nav_xfer;
   logic               chip;
   logic               nh;
   logic               neg;
   logic signed [15:0] cos_v;
   logic signed [15:0] sin_v;

   assign code_sum  = {1'b0, code_acc} + {1'b0, rx_prn_fcw};
   assign tick      = rx_en & code_sum[32];
   assign chip_adv  = tick & (hc_cnt == HC_LAST);
   assign chip_wrap = chip_adv & (chip_cnt == CHIP_LAST);
   assign cp_wrap   = chip_wrap & (cp_cnt == CP_LAST);
   // tx_nav_rdy is the registered "buffer empty" state.
   assign nav_xfer  = sig.rx_nav_vld & sig.tx_nav_rdy;

`ifdef BOC_SIG_GEN_NH_EN
   logic [4:0] nh_idx;
   assign nh_idx = 5'(NH_LEN - 1) - 5'(cp_cnt);
   assign nh     = NH_CODE[nh_idx];
`else
   assign nh = 1'b0;
`endif

   b1_prn_lfsr #(
      .TAP_A (PRN_G2_TAP_A),
      .TAP_B (PRN_G2_TAP_B)
   ) u_prn (
      .clk    (rx_clk),
      .rst    (rx_rst),
      .adv    (chip_adv),
      .reload (chip_wrap),
      .chip   (chip)
   );

   assign neg   = chip ^ subc ^ nav_cur ^ nh;
   assign cos_v = COS_TAB[car_acc[31:29]];
   assign sin_v = SIN_TAB[car_acc[31:29]];

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         code_acc        <= '0;
         car_acc         <= '0;
         subc            <= 1'b0;
         hc_cnt          <= '0;
         chip_cnt        <= '0;
         cp_cnt          <= '0;
         nav_cur         <= 1'b0;
         nav_buf         <= 1'b0;
         sop_pend        <= 1'b1;
         tx_nav_unf      <= 1'b0;
         sig.tx_nav_rdy  <= 1'b1;
         sig.tx_sig_real <= '0;
         sig.tx_sig_imag <= '0;
         sig.tx_sig_vld  <= 1'b0;
         sig.tx_prn_sop  <= 1'b0;
      end else begin
         sig.tx_sig_vld <= rx_en;
         sig.tx_prn_sop <= rx_en & sop_pend;

         // Sample uses the state before this cycle's update.
         if (rx_en) begin
            sig.tx_sig_real <= neg ? (~cos_v + 16'sd1) : cos_v;
            sig.tx_sig_imag <= neg ? (~sin_v + 16'sd1) : sin_v;
            code_acc        <= code_sum[31:0];
            car_acc         <= car_acc + rx_car_fcw;
            sop_pend        <= chip_wrap;
         end

         if (tick) begin
            subc   <= ~subc;
            hc_cnt <= (hc_cnt == HC_LAST) ? '0 : hc_cnt + 1'b1;
         end
         if (chip_adv)
            chip_cnt <= chip_wrap ? '0 : chip_cnt + 1'b1;
         if (chip_wrap)
            cp_cnt <= cp_wrap ? '0 : cp_cnt + 1'b1;

         // Boundary consumes the buffer first; a same-cycle transfer then
         // refills it for the following bit period.
         if (cp_wrap) begin
            nav_cur        <= ~sig.tx_nav_rdy & nav_buf;
            sig.tx_nav_rdy <= 1'b1;
            if (sig.tx_nav_rdy)
               tx_nav_unf <= 1'b1;
         end
         if (nav_xfer) begin
            nav_buf        <= sig.rx_nav_bit;
            sig.tx_nav_rdy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_boc_sig_gen.sv
// tb/tb_boc_sig_gen.sv - scoreboard bench for boc_sig_gen
module tb_boc_sig_gen;

   localparam int     HPC  = 2;      // half-subcarrier ticks per chip
   localparam int     PLEN = 2046;   // chips per code period
   localparam int     CPB  = 2;      // code periods per nav bit (shortened)
   localparam longint TPP  = longint'(HPC) * PLEN;
   localparam longint TPB  = TPP * CPB;

   typedef struct {
      logic               vld;
      logic signed [15:0] re;
      logic signed [15:0] im;
      logic               sop;
      logic               rdy;
      logic               unf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [31:0] car_fcw = '0;
   logic [31:0] prn_fcw = '0;
   logic        nav_bit = 1'b0;
   logic        nav_vld = 1'b0;
   logic        unf;

   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   bit   gold[PLEN];
   bit   started = 1'b0;
   int   cyc = 0;
   int   sop_cyc[$];

   logic [31:0]        m_code_acc, m_car_acc;
   longint             m_ticks, m_last_sop;
   bit                 m_nav_cur, m_buf, m_full, m_unf;
   logic signed [15:0] m_re, m_im;

   always #5 clk = ~clk;

   boc_sig_gen_if sig();
   assign sig.rx_nav_bit = nav_bit;
   assign sig.rx_nav_vld = nav_vld;

   boc_sig_gen #(.CODES_PER_BIT(CPB)) dut (
      .rx_clk     (clk),
      .rx_rst     (rst),
      .rx_en      (en),
      .rx_car_fcw (car_fcw),
      .rx_prn_fcw (prn_fcw),
      .tx_nav_unf (unf),
      .sig        (sig)
   );

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int cos_lut(input int k);
      case (k)
         0: return 8192;
         1: return 5793;
         2: return 0;
         3: return -5793;
         4: return -8192;
         5: return -5793;
         6: return 0;
         default: return 5793;
      endcase
   endfunction

   // Golden Gold code: stages numbered 1..11, seed 01010101010, G2 taps 1 and 3.
   task automatic build_gold();
      int g1[12];
      int g2[12];
      int fb1, fb2;
      for (int i = 1; i <= 11; i++) begin
         g1[i] = (i % 2 == 0) ? 1 : 0;
         g2[i] = g1[i];
      end
      for (int c = 0; c < PLEN; c++) begin
         gold[c] = bit'(g1[11] ^ g2[1] ^ g2[3]);
         fb1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
         fb2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
         for (int i = 11; i >= 2; i--) begin
            g1[i] = g1[i-1];
            g2[i] = g2[i-1];
         end
         g1[1] = fb1;
         g2[1] = fb2;
      end
   endtask

   // Reference model: tick count drives chip/subcarrier/period positions.
   always @(posedge clk) begin
      exp_t       e;
      bit         rdy_b, sgn;
      longint     ci;
      int         k, c, s;
      logic [32:0] sum;
      if (rst) begin
         m_code_acc = '0; m_car_acc = '0; m_ticks = 0; m_last_sop = -1;
         m_nav_cur = 0; m_buf = 0; m_full = 0; m_unf = 0; m_re = '0; m_im = '0;
         e.vld = 1'b0; e.sop = 1'b0;
      end else begin
         rdy_b = !m_full;
         e.vld = en;
         e.sop = 1'b0;
         if (en) begin
            ci  = (m_ticks / HPC) % PLEN;
            sgn = gold[ci] ^ bit'(m_ticks % 2) ^ m_nav_cur;
            k   = int'(m_car_acc >> 29);
            c   = cos_lut(k);
            s   = cos_lut((k + 6) % 8);
            m_re = 16'(sgn ? -c : c);
            m_im = 16'(sgn ? -s : s);
            if ((m_ticks % TPP) == 0 && m_ticks != m_last_sop) begin
               e.sop = 1'b1;
               m_last_sop = m_ticks;
            end
            sum = {1'b0, m_code_acc} + {1'b0, prn_fcw};
            m_code_acc = sum[31:0];
            if (sum[32]) begin
               m_ticks++;
               if ((m_ticks % TPB) == 0) begin
                  if (m_full) m_nav_cur = m_buf;
                  else begin
                     m_nav_cur = 0;
                     m_unf = 1;
                  end
                  m_full = 0;
               end
            end
            m_car_acc = m_car_acc + car_fcw;
         end
         if (nav_vld && rdy_b) begin
            m_buf = nav_bit;
            m_full = 1;
         end
      end
      e.re = m_re; e.im = m_im; e.rdy = !m_full; e.unf = m_unf;
      q.push_back(e);
      started = 1'b1;
   end

   // Monitor: one expected entry per clock, compared on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         cyc++;
         if (q.size() == 0) begin
            chk("queue_underrun", 0, 1);
         end else begin
            e = q.pop_front();
            chk("sig_vld",  sig.tx_sig_vld, e.vld);
            chk("sig_real", $signed(sig.tx_sig_real), e.re);
            chk("sig_imag", $signed(sig.tx_sig_imag), e.im);
            chk("prn_sop",  sig.tx_prn_sop, e.sop);
            chk("nav_rdy",  sig.tx_nav_rdy, e.rdy);
            chk("nav_unf",  unf, e.unf);
            if (sig.tx_prn_sop && sig.tx_sig_vld) sop_cyc.push_back(cyc);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      build_gold();
      cycles(3);
      chk("rst_vld",  sig.tx_sig_vld, 0);
      chk("rst_real", sig.tx_sig_real, 0);
      chk("rst_rdy",  sig.tx_nav_rdy, 1);
      chk("rst_unf",  unf, 0);

      // Phase A: one chip per 4 cycles, carrier fixed, one nav bit = 1.
      rst = 1'b0; en = 1'b1; prn_fcw = 32'h8000_0000; car_fcw = '0;
      nav_bit = 1'b1; nav_vld = 1'b1;
      cycles(1);
      chk("rdy_drop", sig.tx_nav_rdy, 0);
      nav_vld = 1'b0; nav_bit = 1'b0;
      cycles(9000);
      chk("sop_count", (sop_cyc.size() >= 2) ? 1 : 0, 1);
      if (sop_cyc.size() >= 2) chk("sop_period", sop_cyc[1] - sop_cyc[0], 8184);
      en = 1'b0;
      cycles(100);
      en = 1'b1;
      cycles(7900);
      chk("rdy_after_bit", sig.tx_nav_rdy, 1);
      chk("unf_after_bit", unf, 0);

      // Withhold nav across the next boundary.
      cycles(16400);
      chk("unf_set", unf, 1);

      // Randomised phase: carrier, code rate, enable and nav offers.
      for (int i = 0; i < 15000; i++) begin
         if (i % 500 == 0) begin
            prn_fcw = $urandom_range(32'h8000_0000, 0);
            car_fcw = $urandom;
         end
         en      = ($urandom_range(7, 0) != 0);
         nav_vld = ($urandom_range(3, 0) == 0);
         nav_bit = $urandom_range(1, 0);
         cycles(1);
      end
      chk("unf_sticky", unf, 1);

      // Mid-period reset, then restart from chip 0.
      en = 1'b1; nav_vld = 1'b0; rst = 1'b1;
      cycles(1);
      chk("mid_rst_vld",  sig.tx_sig_vld, 0);
      chk("mid_rst_imag", sig.tx_sig_imag, 0);
      chk("mid_rst_rdy",  sig.tx_nav_rdy, 1);
      chk("mid_rst_unf",  unf, 0);
      rst = 1'b0; prn_fcw = 32'h8000_0000; car_fcw = 32'h1234_5678;
      for (int i = 0; i < 3000; i++) begin
         nav_vld = ($urandom_range(15, 0) == 0);
         nav_bit = $urandom_range(1, 0);
         cycles(1);
      end
      en = 1'b0; nav_vld = 1'b0;
      cycles(2);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/boc_sig_gen.md
# boc_sig_gen

B1 BOC(1,1) baseband signal generator. It produces the complex 16-bit sample stream that the tracking loop consumes: a carrier NCO, a Gold-code PRN generator with BOC subcarrier, and a navigation-bit modulator fed through a valid/ready handshake. The block sits at the head of the loopback and test datapath and feeds tracking's `rx_src_real` and `rx_src_imag` directly.

## Interface
- `PRN_G2_TAP_A`, default 1: first G2 tap (1..11) for phase selection.
- `PRN_G2_TAP_B`, default 3: second G2 tap (1..11).
- `PRN_LEN`, default 2046: chips per code period.
- `SUBC_HALF_PER_CHIP`, default 2: subcarrier half-periods per chip (2 = BOC(1,1)).
- `CODES_PER_BIT`, default 20: code periods per nav bit.
- `rx_clk`  in  1  clock; the only clock.
- `rx_rst`  in  1  reset, synchronous, active-high.
- `rx_en`  in  1  advance NCOs and generators when high; freeze when low.
- `rx_car_fcw`  in  32  carrier frequency control word.
- `rx_prn_fcw`  in  32  subcarrier half-period frequency control word.
- `rx_nav_bit`  in  1  next navigation bit.
- `rx_nav_vld`  in  1  `rx_nav_bit` is valid.
- `tx_nav_rdy`  out  1  the one-entry nav buffer is empty.
- `tx_sig_real`  out  16  I sample, two's complement.
- `tx_sig_imag`  out  16  Q sample, two's complement.
- `tx_sig_vld`  out  1  sample valid.
- `tx_prn_sop`  out  1  first sample of a code period.
- `tx_nav_unf`  out  1  sticky nav underflow flag.

## Operation
- **Code NCO**: 32-bit accumulator `code_acc += rx_prn_fcw` when `rx_en` is high. A carry out is one half-subcarrier tick.
  - Each tick toggles `subc`.
  - Tick counter `hc_cnt` runs 0..`SUBC_HALF_PER_CHIP`-1; its wrap advances the chip.
- **PRN**: two 11-bit LFSRs.
  - G1 = 1+x+x^7+x^8+x^9+x^10+x^11.
  - G2 = 1+x+x^2+x^3+x^4+x^5+x^8+x^9+x^11.
  - Both initialise to 01010101010.
  - Chip = G1[11] ^ G2[TAP_A] ^ G2[TAP_B].
  - Chip counter runs 0..`PRN_LEN`-1. On wrap, both LFSRs reload their initial value; this truncates the 2047-chip sequence.
- **Code sign**: `code_sgn` = chip ^ `subc`; 1 means negate.
- **Code periods**: counter `cp_cnt` runs 0..`CODES_PER_BIT`-1 and advances on each chip-counter wrap.
- **Nav bit boundary** (wrap of `cp_cnt`):
  - `nav_cur` takes the buffered bit and the buffer empties.
  - If the buffer is empty at the boundary, `nav_cur` is 0 and `tx_nav_unf` sets. `tx_nav_unf` clears only on reset.
- **Nav handshake**: a transfer happens when `rx_nav_vld && tx_nav_rdy`.
  - A transfer in the same cycle as a boundary loads the buffer after the boundary consumes it. That bit belongs to the next bit period.
- **Carrier**: 32-bit `car_acc += rx_car_fcw`. `car_acc[31:29]` indexes an 8-entry cos/sin table, amplitude `AMP` = 16'sd8192.
- **Sample**: the table value negated when `code_sgn ^ nav_cur ^ nh` is 1. Negation is two's complement (`~x+1`). Table entries never reach -32768, so there is no overflow.

## Timing
- **Reset values**:
  - All outputs are 0.
  - `tx_nav_rdy` is 1.
  - Accumulators, counters, `subc` and `nav_cur` are 0.
  - LFSRs hold their initial value.
  - The nav buffer is empty.
- **Latency**: outputs are registered. The sample at cycle n+1 is computed from the state at cycle n, before that cycle's update.
  - `tx_sig_vld` is `rx_en` delayed by one cycle.
  - `tx_prn_sop` is high for exactly one cycle: the valid sample whose chip index is 0, `hc_cnt` is 0 and the preceding state was index `PRN_LEN`-1.
  - The first sample after reset also asserts `tx_prn_sop`.
- **`rx_en` low**: all state holds, `tx_sig_vld` is 0 and sample outputs hold their last value. The nav handshake still operates.
- **Reset mid-operation**: everything returns to reset values on the next edge, including the sticky flag and the buffered bit.
- **FCW limits**: `rx_prn_fcw` ≤ 2^31, so at most one tick per cycle. FCW changes take effect on the next accumulation.

## Configuration
- `BOC_SIG_GEN_NH_EN` defined: a 20-bit NH secondary code 00000100110101001110, MSB first and indexed by `cp_cnt`, supplies `nh`.
- `BOC_SIG_GEN_NH_EN` undefined: `nh` is tied to 0 and the NH logic is absent.

## Structure
- The package `boc_sig_pkg` holds:
  - `AMP`;
  - the 8-entry cos/sin table as a constant array;
  - the G1/G2 initial value and feedback masks;
  - the NH code constant.
- One sub-module, `b1_prn_lfsr`: the G1/G2 pair with taps, `adv` and `reload` inputs and a `chip` output.

## Test plan
1. **Reset and code period**: reset, then `rx_en`=1, `rx_prn_fcw`=0x80000000 → one chip per 4 cycles; `tx_prn_sop` period is 8184 cycles.
2. **Chip sequence**: same setup → the first 64 chips match the golden G1/G2 model (TAP 1,3).
3. **Carrier and sign**: `rx_car_fcw`=0, nav 0, and `BOC_SIG_GEN_NH_EN` undefined for this scenario so `nh`=0 → `tx_sig_imag`=0 and `tx_sig_real`=±8192. The sign follows chip ^ `subc` and flips every 2 cycles within a chip.
4. **Nav handshake**: present `rx_nav_bit`=1 with valid → `tx_nav_rdy` drops the next cycle. After the 20th `tx_prn_sop` the sample sign inverts and `tx_nav_rdy` returns to 1.
5. **Underflow**: withhold `rx_nav_vld` across a bit boundary → `tx_nav_unf`=1 and the sign is not inverted. The flag stays set until `rx_rst`.
6. **Freeze and mid-reset**: hold `rx_en`=0 for 100 cycles → outputs are frozen and `tx_sig_vld`=0, and resuming continues the exact chip sequence. Pulse `rx_rst` mid-period → reset values, and the sequence restarts from chip 0.
